// File: rtl/prog_sequencer.sv
// Program sequencer for the single-cycle CPU: owns the PC, retires one instruction
// per cycle, stalls in MEM until the data memory acknowledges, and stops on HALT.
module prog_sequencer #(
    parameter int PC_W        = 10,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       opcode,
    input  logic [4:0]       operand,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  target,
    input  logic             mem_ready,
    output logic [PC_W-1:0]  pc,
    output logic             exec_en,
    output logic             mem_req,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] cycle_count
);

    // Handshake: mem_req stays high for every MEM cycle; the access completes on
    // the first cycle mem_ready is sampled high while mem_req is high.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_MEM   = 3'd2,
        S_DONE  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    state_t        state;
    logic [TW-1:0] tcnt;
    logic          is_halt;
    logic          is_mem;
    logic          tmo_hit;

    assign is_halt = (opcode == 4'b1111) && (operand == 5'b11111);
    assign is_mem  = (opcode == 4'b1011) || (opcode == 4'b1100);
    assign tmo_hit = (tcnt == TW'(MEM_TIMEOUT - 1));

    assign busy    = (state == S_RUN) || (state == S_MEM);
    assign done    = (state == S_DONE);
    assign error   = (state == S_ERROR);
    assign mem_req = (state == S_MEM);

    always_comb begin
        exec_en = 1'b0;
        case (state)
            S_RUN:   exec_en = !is_halt && !is_mem;
            S_MEM:   exec_en = mem_ready;
            default: exec_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= '0;
            cycle_count <= '0;
            tcnt        <= '0;
        end else begin
            if (busy && (cycle_count != {CNT_W{1'b1}}))
                cycle_count <= cycle_count + CNT_W'(1);

            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state       <= S_RUN;
                        pc          <= '0;
                        cycle_count <= '0;
                    end
                end
                S_RUN: begin
                    if (is_halt) begin
                        state <= S_DONE;
                    end else if (is_mem) begin
                        state <= S_MEM;
                        tcnt  <= '0;
                    end else if (branch_taken) begin
                        pc <= target;
                    end else begin
                        pc <= pc + PC_W'(1);
                    end
                end
                S_MEM: begin
                    // Completion wins over a timeout landing on the same cycle.
                    if (mem_ready) begin
                        pc    <= pc + PC_W'(1);
                        state <= S_RUN;
                    end else if (tmo_hit) begin
                        state <= S_ERROR;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: per-cycle vector table over several programs,
// plus hand sequences for async reset, start-while-busy and PC wrap/saturation.
module tb_prog_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  opcode;
    logic [4:0]  operand;
    logic        branch_taken;
    logic [9:0]  target;
    logic        mem_ready;
    logic [9:0]  pc;
    logic        exec_en;
    logic        mem_req;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] cycle_count;

    logic        start4;
    logic [3:0]  pc4;
    logic        exec_en4;
    logic        mem_req4;
    logic        busy4;
    logic        done4;
    logic        error4;
    logic [3:0]  cycle_count4;

    logic [8:0]  rom     [0:1023];
    logic        bt_rom  [0:1023];
    logic [9:0]  tgt_rom [0:1023];

    int n_chk;
    int n_fail;

    assign {opcode, operand} = rom[pc];
    assign branch_taken      = bt_rom[pc];
    assign target            = tgt_rom[pc];

    prog_sequencer u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode), .operand(operand),
        .branch_taken(branch_taken), .target(target), .mem_ready(mem_ready),
        .pc(pc), .exec_en(exec_en), .mem_req(mem_req), .busy(busy), .done(done),
        .error(error), .cycle_count(cycle_count)
    );

    // Small instance: 16-word ROM of NOPs, 4-bit counter to exercise wrap and saturation.
    prog_sequencer #(.PC_W(4), .CNT_W(4), .MEM_TIMEOUT(15)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .opcode(4'b1111), .operand(5'b00000),
        .branch_taken(1'b0), .target(4'd0), .mem_ready(mem_ready),
        .pc(pc4), .exec_en(exec_en4), .mem_req(mem_req4), .busy(busy4), .done(done4),
        .error(error4), .cycle_count(cycle_count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          scen;
        logic        start;
        logic        mr;
        logic [9:0]  pc;
        logic        ex;
        logic        mq;
        logic        bz;
        logic        dn;
        logic        er;
        logic [15:0] cnt;
    } vec_t;

    vec_t vecs [0:79];
    int   nvec;

    localparam logic [8:0] ADD  = 9'b0000_00001;
    localparam logic [8:0] HALT = 9'b1111_11111;
    localparam logic [8:0] NEAR = 9'b1111_11110;
    localparam logic [8:0] BEQ  = 9'b1001_00000;
    localparam logic [8:0] LW   = 9'b1100_00010;
    localparam logic [8:0] SW   = 9'b1011_00011;

    task automatic add(input int s, input logic st, input logic mr, input logic [9:0] p,
                       input logic ex, input logic mq, input logic bz, input logic dn,
                       input logic er, input logic [15:0] cnt);
        vecs[nvec] = '{s, st, mr, p, ex, mq, bz, dn, er, cnt};
        nvec++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic load_rom(input int s);
        for (int i = 0; i < 1024; i++) begin
            rom[i]     = ADD;
            bt_rom[i]  = 1'b0;
            tgt_rom[i] = 10'd0;
        end
        case (s)
            1: rom[3] = HALT;
            2: begin
                rom[1] = NEAR;
                rom[2] = BEQ;
                bt_rom[2] = 1'b1;
                tgt_rom[2] = 10'd7;
                rom[7] = HALT;
            end
            3: begin
                rom[1] = LW;
                rom[2] = HALT;
            end
            4: begin
                rom[0] = SW;
                rom[1] = HALT;
            end
            5: rom[2] = LW;
            default: ;
        endcase
    endtask

    task automatic check_vec(input int i);
        string t;
        t = $sformatf("v%0d_s%0d", i, vecs[i].scen);
        chk({t, "_pc"},   32'(pc),          32'(vecs[i].pc));
        chk({t, "_exec"}, 32'(exec_en),     32'(vecs[i].ex));
        chk({t, "_mreq"}, 32'(mem_req),     32'(vecs[i].mq));
        chk({t, "_busy"}, 32'(busy),        32'(vecs[i].bz));
        chk({t, "_done"}, 32'(done),        32'(vecs[i].dn));
        chk({t, "_err"},  32'(error),       32'(vecs[i].er));
        chk({t, "_cnt"},  32'(cycle_count), 32'(vecs[i].cnt));
    endtask

    initial begin
        int cur;
        n_chk = 0;
        n_fail = 0;
        nvec = 0;
        start = 1'b0;
        start4 = 1'b0;
        mem_ready = 1'b0;
        rst_n = 1'b0;
        load_rom(1);

        // scen s, start, mem_ready | pc exec mreq busy done err cnt
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        add(1, 0, 0, 1, 1, 0, 1, 0, 0, 1);
        add(1, 0, 0, 2, 1, 0, 1, 0, 0, 2);
        add(1, 0, 0, 3, 0, 0, 1, 0, 0, 3);
        add(1, 0, 0, 3, 0, 0, 0, 1, 0, 4);
        // branch at 2 -> 7; start while running must be ignored
        add(2, 1, 0, 3, 0, 0, 0, 1, 0, 4);
        add(2, 1, 0, 0, 1, 0, 1, 0, 0, 0);
        add(2, 0, 0, 1, 1, 0, 1, 0, 0, 1);
        add(2, 0, 0, 2, 1, 0, 1, 0, 0, 2);
        add(2, 0, 0, 7, 0, 0, 1, 0, 0, 3);
        add(2, 0, 0, 7, 0, 0, 0, 1, 0, 4);
        // LW at 1, ready on third MEM cycle
        add(3, 1, 0, 7, 0, 0, 0, 1, 0, 4);
        add(3, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        add(3, 0, 1, 1, 0, 0, 1, 0, 0, 1);
        add(3, 0, 0, 1, 0, 1, 1, 0, 0, 2);
        add(3, 0, 0, 1, 0, 1, 1, 0, 0, 3);
        add(3, 0, 1, 1, 1, 1, 1, 0, 0, 4);
        add(3, 0, 0, 2, 0, 0, 1, 0, 0, 5);
        add(3, 0, 0, 2, 0, 0, 0, 1, 0, 6);
        // SW at 0 times out after 15 MEM cycles, then restart with ready on the 15th
        add(4, 1, 0, 2, 0, 0, 0, 1, 0, 6);
        add(4, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 15; k++) add(4, 0, 0, 0, 0, 1, 1, 0, 0, 16'(k));
        add(4, 0, 0, 0, 0, 0, 0, 0, 1, 16);
        add(4, 1, 1, 0, 0, 0, 0, 0, 1, 16);
        add(4, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 14; k++) add(4, 0, 0, 0, 0, 1, 1, 0, 0, 16'(k));
        add(4, 0, 1, 0, 1, 1, 1, 0, 0, 15);
        add(4, 0, 0, 1, 0, 0, 1, 0, 0, 16);
        add(4, 0, 0, 1, 0, 0, 0, 1, 0, 17);

        repeat (2) @(negedge clk);
        chk("reset_pc",    32'(pc), 0);
        chk("reset_busy",  32'(busy), 0);
        chk("reset_cnt",   32'(cycle_count), 0);
        chk("reset_pc4",   32'(pc4), 0);
        chk("reset_done4", 32'(done4), 0);
        rst_n = 1'b1;

        cur = 1;
        for (int i = 0; i < nvec; i++) begin
            @(negedge clk);
            if (vecs[i].scen != cur) begin
                cur = vecs[i].scen;
                load_rom(cur);
            end
            start = vecs[i].start;
            mem_ready = vecs[i].mr;
            #1;
            check_vec(i);
        end
        @(negedge clk);
        start = 1'b0;
        mem_ready = 1'b0;

        // Async reset while stalled in MEM at pc=2
        load_rom(5);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_mreq", 32'(mem_req), 1);
        chk("pre_rst_pc",   32'(pc), 2);
        mem_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pc",   32'(pc), 0);
        chk("rst_mreq", 32'(mem_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_exec", 32'(exec_en), 0);
        chk("rst_cnt",  32'(cycle_count), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err",  32'(error), 0);
        @(negedge clk);
        chk("rst_held_pc", 32'(pc), 0);
        rst_n = 1'b1;
        mem_ready = 1'b0;

        // Start pulse during RUN must not restart the program
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("run_pc1", 32'(pc), 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #1;
        chk("run_start_ign_pc", 32'(pc), 2);
        chk("run_start_ign_busy", 32'(busy), 1);

        // PC_W=4 instance: NOPs wrap 15->0, counter saturates at 15
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("w%0d_pc4", i),   32'(pc4), 32'(i % 16));
            chk($sformatf("w%0d_exec4", i), 32'(exec_en4), 1);
            chk($sformatf("w%0d_done4", i), 32'(done4), 0);
            chk($sformatf("w%0d_cnt4", i),  32'(cycle_count4), 32'((i > 15) ? 15 : i));
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Sequences the single-cycle CPU datapath: owns the program counter, steps one instruction per cycle, and stalls on data-memory ops until the memory acknowledges.
- Redirects on taken branches and stops on the halt instruction.
- Qualifies the Control unit's RegWrite/MemWrite through exec_en, so writes commit only when an instruction actually retires.
- Sits between the instruction ROM / Control decode and the PC/regfile/data-memory write enables; reports start/done to the top-level bench.

Parameters:
PC_W, 10, program counter width; instruction ROM depth 2^PC_W
CNT_W, 16, retired-cycle counter width
MEM_TIMEOUT, 15, max cycles in MEM waiting for mem_ready before error (must be >=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin program at pc=0 (sampled in IDLE/DONE/ERROR only)
opcode  input  4  instr[8:5] of the instruction at pc (combinational from ROM)
operand  input  5  instr[4:0] of the instruction at pc
branch_taken  input  1  Control Branch output for current instruction
target  input  PC_W  branch target from the branch LUT
mem_ready  input  1  data memory completion strobe
pc  output  PC_W  current program counter
exec_en  output  1  current instruction retires this cycle; gates RegWrite/MemWrite
mem_req  output  1  data-memory access in progress
busy  output  1  state is RUN or MEM
done  output  1  halt reached; held until next start
error  output  1  memory timeout; held until next start
cycle_count  output  CNT_W  cycles spent in RUN+MEM for this program

Behaviour:
- Reset (async, rst_n=0): state=IDLE; pc=0, cycle_count=0, timeout counter=0; all 1-bit outputs 0. Reset mid-program aborts immediately with no further writes.
- States: IDLE, RUN, MEM, DONE, ERROR. pc, cycle_count and state are registers. exec_en and mem_req are combinational from state plus inputs.
- IDLE/DONE/ERROR, start=1: next state RUN, pc<=0, cycle_count<=0, done<=0, error<=0.
- IDLE/DONE/ERROR, start=0: hold. done=1 only in DONE; error=1 only in ERROR.
- start while busy: ignored.
- RUN, halt (opcode=4'b1111 and operand=5'b11111): exec_en=0; next state DONE; pc holds.
- RUN, memory op (opcode 4'b1011 SW or 4'b1100 LW): exec_en=0; next state MEM; timeout counter<=0; pc holds.
- RUN, any other opcode (includes NOP 1111 with operand != 11111, and BNE/BEQ): exec_en=1.
  - branch_taken=1: pc<=target.
  - Otherwise: pc<=pc+1, wrapping modulo 2^PC_W (2^PC_W-1 -> 0).
- MEM: mem_req=1.
  - mem_ready=1: exec_en=1 that same cycle; pc<=pc+1; next state RUN. Memory ops never branch, so branch_taken is ignored in MEM.
  - mem_ready=0: timeout counter increments. When the counter reaches MEM_TIMEOUT with mem_ready still 0, next state ERROR, exec_en=0, pc holds.
  - mem_ready=1 on the timeout cycle: completion wins.
- mem_ready outside MEM: ignored.
- cycle_count: +1 on every clock edge where state is RUN or MEM; saturates at 2^CNT_W-1. Not cleared by DONE; cleared only on start or reset.
- busy = (state==RUN || state==MEM).
- Latency: non-memory instruction = 1 cycle. Memory instruction = 1 + k cycles, where k = cycles in MEM up to and including the mem_ready cycle.

Test Plan:
1. Reset, then start pulse; ROM = ADD, ADD, ADD, HALT(1111_11111) -> pc steps 0,1,2,3; exec_en=1 for 3 cycles; done=1 from cycle 5; cycle_count=4; busy=0.
2. BEQ at pc=2 with branch_taken=1, target=7, HALT at 7 -> pc sequence 0,1,2,7; exec_en=1 at pc=2; done; cycle_count=4.
3. LW at pc=1, mem_ready asserted on 3rd MEM cycle -> mem_req=1 for 3 cycles; exec_en=0 then 1 on the mem_ready cycle; pc 1->2 only then; cycle_count includes the 4 cycles.
4. SW at pc=0, mem_ready never asserted, MEM_TIMEOUT=15 -> after 15 MEM cycles error=1, busy=0, pc=0, no exec_en pulse; next start clears error and restarts at pc=0.
5. PC_W=4, NOPs (1111_00000) filling all 16 words -> pc wraps 15->0; exec_en stays 1; done never asserts.
6. rst_n dropped while in MEM, then start pulsed during RUN -> all outputs 0 asynchronously, state IDLE; the start pulse during RUN causes no pc reset.
